// File: rtl/div_arbiter.sv
// Two-port round-robin front end for the shared sequential divider: launches a job,
// waits for completion under a watchdog, returns the result. DIV_ARB_ZERO_BYPASS_EN answers b==0 without launching.
module div_arbiter #(
   parameter int W         = 8,
   parameter int START_CYC = 2,
   parameter int TIMEOUT   = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0_valid,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         req1_ready,
   output logic         rsp_valid0,
   output logic         rsp_valid1,
   output logic [W-1:0] rsp_q,
   output logic [W-1:0] rsp_r,
   output logic         rsp_err,
   output logic         rsp_timeout,
   output logic         dv_start,
   output logic [W-1:0] dv_a,
   output logic [W-1:0] dv_b,
   input  logic [W-1:0] dv_div,
   input  logic [W-1:0] dv_mod,
   input  logic         dv_ready,
   input  logic         dv_err,
   output logic         busy
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LAUNCH = 3'd1;
   localparam logic [2:0] S_ACK    = 3'd2;
   localparam logic [2:0] S_RUN    = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam logic [2:0] LAUNCH_LAST = 3'(START_CYC - 1);
   localparam logic [7:0] WD_LIMIT    = 8'(TIMEOUT);

   logic [2:0]   state_q, state_d;
   logic [2:0]   lcnt_q, lcnt_d;
   logic [7:0]   wd_q, wd_d;
   logic         owner_q, owner_d;
   logic         pref_q, pref_d;
   logic [W-1:0] dv_a_q, dv_a_d, dv_b_q, dv_b_d;
   logic         dv_start_q, dv_start_d;
   logic         rsp_valid0_q, rsp_valid0_d, rsp_valid1_q, rsp_valid1_d;
   logic [W-1:0] rsp_quo_q, rsp_quo_d, rsp_rem_q, rsp_rem_d;
   logic         rsp_err_q, rsp_err_d, rsp_timeout_q, rsp_timeout_d;
   logic         busy_q, busy_d;

   logic         grant;
   logic         handshake;
   logic [W-1:0] a_sel, b_sel;
   logic [7:0]   wd_inc;

   // pref_q names the requester that wins a tie; it flips away from every winner
   always_comb begin
      if (req0_valid && !req1_valid) begin
         grant = 1'b0;
      end else if (req1_valid && !req0_valid) begin
         grant = 1'b1;
      end else begin
         grant = pref_q;
      end
   end

   assign req0_ready = (state_q == S_IDLE) && !grant;
   assign req1_ready = (state_q == S_IDLE) && grant;
   assign handshake  = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   assign a_sel      = grant ? req1_a : req0_a;
   assign b_sel      = grant ? req1_b : req0_b;
   assign wd_inc     = wd_q + 8'd1;

   always_comb begin
      state_d       = state_q;
      lcnt_d        = lcnt_q;
      wd_d          = wd_q;
      owner_d       = owner_q;
      pref_d        = pref_q;
      dv_a_d        = dv_a_q;
      dv_b_d        = dv_b_q;
      dv_start_d    = 1'b0;
      rsp_valid0_d  = 1'b0;
      rsp_valid1_d  = 1'b0;
      rsp_quo_d     = rsp_quo_q;
      rsp_rem_d     = rsp_rem_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      case (state_q)
         S_IDLE: begin
            if (handshake) begin
               owner_d = grant;
               pref_d  = !grant;
               dv_a_d  = a_sel;
               dv_b_d  = b_sel;
               lcnt_d  = 3'd0;
               wd_d    = 8'd0;
`ifdef DIV_ARB_ZERO_BYPASS_EN
               if (b_sel == '0) begin
                  state_d       = S_DONE;
                  rsp_quo_d     = '1;
                  rsp_rem_d     = a_sel;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b0;
                  rsp_valid0_d  = !grant;
                  rsp_valid1_d  = grant;
               end else begin
                  state_d    = S_LAUNCH;
                  dv_start_d = 1'b1;
               end
`else
               state_d    = S_LAUNCH;
               dv_start_d = 1'b1;
`endif
            end
         end
         S_LAUNCH: begin
            if (lcnt_q == LAUNCH_LAST) begin
               state_d = S_ACK;
               wd_d    = 8'd0;
            end else begin
               lcnt_d     = lcnt_q + 3'd1;
               dv_start_d = 1'b1;
            end
         end
         S_ACK, S_RUN: begin
            wd_d = wd_inc;
            // a genuine completion in RUN beats a watchdog expiring on the same edge
            if (state_q == S_RUN && dv_ready) begin
               state_d       = S_DONE;
               rsp_quo_d     = dv_div;
               rsp_rem_d     = dv_mod;
               rsp_err_d     = dv_err;
               rsp_timeout_d = 1'b0;
               rsp_valid0_d  = !owner_q;
               rsp_valid1_d  = owner_q;
            end else if (wd_inc == WD_LIMIT) begin
               state_d       = S_DONE;
               rsp_quo_d     = '0;
               rsp_rem_d     = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_valid0_d  = !owner_q;
               rsp_valid1_d  = owner_q;
            end else if (state_q == S_ACK && !dv_ready) begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         lcnt_q        <= 3'd0;
         wd_q          <= 8'd0;
         owner_q       <= 1'b0;
         pref_q        <= 1'b0;
         dv_a_q        <= '0;
         dv_b_q        <= '0;
         dv_start_q    <= 1'b0;
         rsp_valid0_q  <= 1'b0;
         rsp_valid1_q  <= 1'b0;
         rsp_quo_q     <= '0;
         rsp_rem_q     <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         lcnt_q        <= lcnt_d;
         wd_q          <= wd_d;
         owner_q       <= owner_d;
         pref_q        <= pref_d;
         dv_a_q        <= dv_a_d;
         dv_b_q        <= dv_b_d;
         dv_start_q    <= dv_start_d;
         rsp_valid0_q  <= rsp_valid0_d;
         rsp_valid1_q  <= rsp_valid1_d;
         rsp_quo_q     <= rsp_quo_d;
         rsp_rem_q     <= rsp_rem_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         busy_q        <= busy_d;
      end
   end

   assign dv_start    = dv_start_q;
   assign dv_a        = dv_a_q;
   assign dv_b        = dv_b_q;
   assign rsp_valid0  = rsp_valid0_q;
   assign rsp_valid1  = rsp_valid1_q;
   assign rsp_q       = rsp_quo_q;
   assign rsp_r       = rsp_rem_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Randomized self-checking bench for div_arbiter with a behavioural divider stand-in.
// Expected results come from plain arithmetic and the round-robin rule.
module tb_div_arbiter;

   logic       clk;
   logic       reset;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_a, req0_b, req1_a, req1_b;
   logic       req0_ready, req1_ready;
   logic       rsp_valid0, rsp_valid1;
   logic [7:0] rsp_q, rsp_r;
   logic       rsp_err, rsp_timeout;
   logic       dv_start;
   logic [7:0] dv_a, dv_b;
   logic [7:0] m_div, m_mod;
   logic       m_ready, m_err;
   logic       busy;

   int  n_cmp = 0;
   int  n_bad = 0;
   int  m_lat = 10;
   int  m_cnt;
   bit  m_hang = 0;
   int  dvs_cnt = 0;
   int  v0_cnt = 0;
   int  v1_cnt = 0;
   bit  tb_pref = 0;

   div_arbiter #(.W(8), .START_CYC(2), .TIMEOUT(64)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1), .rsp_q(rsp_q), .rsp_r(rsp_r),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .dv_start(dv_start), .dv_a(dv_a), .dv_b(dv_b),
      .dv_div(m_div), .dv_mod(m_mod), .dv_ready(m_ready), .dv_err(m_err),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // divider stand-in: takes a job on dv_start, drops ready, returns after m_lat edges
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_ready <= 1'b1;
         m_cnt   <= 0;
         m_div   <= 8'h00;
         m_mod   <= 8'h00;
         m_err   <= 1'b0;
      end else if (m_cnt > 0) begin
         if (!m_hang) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_ready <= 1'b1;
         end
      end else if (dv_start && m_ready) begin
         m_ready <= 1'b0;
         m_cnt   <= m_lat;
         m_div   <= (dv_b == 8'h00) ? 8'hFF : dv_a / dv_b;
         m_mod   <= (dv_b == 8'h00) ? dv_a : dv_a % dv_b;
         m_err   <= (dv_b == 8'h00);
      end
   end

   always @(negedge clk) begin
      if (dv_start) dvs_cnt++;
      if (rsp_valid0) v0_cnt++;
      if (rsp_valid1) v1_cnt++;
   end

   function automatic logic [7:0] ref_q(input logic [7:0] a, input logic [7:0] b);
      return (b == 8'h00) ? 8'hFF : a / b;
   endfunction
   function automatic logic [7:0] ref_r(input logic [7:0] a, input logic [7:0] b);
      return (b == 8'h00) ? a : a % b;
   endfunction

   task automatic reset_dut();
      @(negedge clk);
      reset = 1'b0;
      m_hang = 0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      tb_pref = 0;
   endtask

   // called at/near a negedge; returns #1 after the accepting edge
   task automatic wait_handshake(input bit scramble, output bit ok, output int port,
                                 output logic [7:0] ha, output logic [7:0] hb, output int early);
      ok = 0; port = -1; ha = 0; hb = 0; early = 0;
      for (int i = 0; i < 400; i++) begin
         if (scramble && busy) begin
            if (req0_valid) req0_b = 8'($urandom_range(0, 255));
            if (req1_valid) req1_b = 8'($urandom_range(0, 255));
         end
         #1;
         if (busy && (req0_ready || req1_ready)) early++;
         if (req0_valid && req0_ready) begin
            port = 0; ha = req0_a; hb = req0_b;
         end else if (req1_valid && req1_ready) begin
            port = 1; ha = req1_a; hb = req1_b;
         end
         if (port >= 0) begin
            @(posedge clk);
            #1;
            if (port == 0) req0_valid = 1'b0;
            else req1_valid = 1'b0;
            ok = 1;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_rsp(output bit ok, output int which, output logic [7:0] q, output logic [7:0] r,
                           output logic err, output logic tmo, output int cyc);
      ok = 0; which = -1; q = 0; r = 0; err = 0; tmo = 0; cyc = 0;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (rsp_valid0 || rsp_valid1) begin
            ok = 1;
            which = rsp_valid1 ? (rsp_valid0 ? 2 : 1) : 0;
            q = rsp_q; r = rsp_r; err = rsp_err; tmo = rsp_timeout; cyc = i;
            return;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #3;
      n_cmp++;
      if ({busy, dv_start, rsp_valid0, rsp_valid1, rsp_err, rsp_timeout} !== 6'b0) begin
         n_bad++; $display("FAIL reset_ctrl: got %b want 000000", {busy, dv_start, rsp_valid0, rsp_valid1, rsp_err, rsp_timeout});
      end
      n_cmp++;
      if ({rsp_q, rsp_r, dv_a, dv_b} !== 32'h0) begin
         n_bad++; $display("FAIL reset_data: got %h want 00000000", {rsp_q, rsp_r, dv_a, dv_b});
      end
      reset_dut();
      $display("test_reset: outputs checked during reset");
   endtask

   task automatic test_basic();
      bit ok; int port, early, which, cyc; logic [7:0] ha, hb, q, r; logic err, tmo;
      reset_dut();
      m_lat = 10;
      req0_a = 8'h08; req0_b = 8'h02; req0_valid = 1'b1;
      dvs_cnt = 0; v0_cnt = 0; v1_cnt = 0;
      wait_handshake(0, ok, port, ha, hb, early);
      n_cmp++;
      if (!ok || port != 0) begin n_bad++; $display("FAIL basic_hs: got ok=%0d port=%0d want 1/0", ok, port); end
      wait_rsp(ok, which, q, r, err, tmo, cyc);
      n_cmp++;
      if (!ok || which != 0) begin n_bad++; $display("FAIL basic_rsp: got ok=%0d which=%0d want 1/0", ok, which); end
      n_cmp++;
      if ({q, r, err, tmo} !== {8'd4, 8'd0, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL basic_val: got q=%0d r=%0d err=%b tmo=%b want 4 0 0 0", q, r, err, tmo);
      end
      n_cmp++;
      if (cyc != m_lat + 3) begin n_bad++; $display("FAIL basic_lat: got %0d want %0d", cyc, m_lat + 3); end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (dvs_cnt != 2) begin n_bad++; $display("FAIL basic_start_len: got %0d want 2", dvs_cnt); end
      n_cmp++;
      if (v0_cnt != 1 || v1_cnt != 0) begin n_bad++; $display("FAIL basic_pulse: got v0=%0d v1=%0d want 1 0", v0_cnt, v1_cnt); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle: got busy=%b want 0", busy); end
      $display("test_basic: 8/2 q=%0d r=%0d err=%b lat=%0d", q, r, err, cyc);
   endtask

   task automatic test_arbitration();
      bit ok; int port, early, which, cyc, exp_port; logic [7:0] ha, hb, q, r; logic err, tmo;
      logic [1:0] pending;
      reset_dut();
      for (int it = 0; it < 14; it++) begin
         @(negedge clk);
         if (it < 3) begin
            pending = 2'b11;
            req0_a = 8'd100; req0_b = 8'd7; req1_a = 8'd9; req1_b = 8'd4;
            m_lat = 10;
         end else begin
            pending = 2'($urandom_range(1, 3));
            req0_a = 8'($urandom_range(0, 255)); req0_b = 8'($urandom_range(0, 255));
            req1_a = 8'($urandom_range(0, 255)); req1_b = 8'($urandom_range(0, 255));
            m_lat = $urandom_range(2, 12);
         end
         req0_valid = pending[0];
         req1_valid = pending[1];
         while (pending != 2'b00) begin
            exp_port = (pending == 2'b11) ? int'(tb_pref) : (pending[0] ? 0 : 1);
            wait_handshake(it >= 3, ok, port, ha, hb, early);
            n_cmp++;
            if (!ok || port != exp_port) begin
               n_bad++; $display("FAIL arb_grant it=%0d: got ok=%0d port=%0d want %0d", it, ok, port, exp_port);
            end
            if (!ok) begin
               req0_valid = 1'b0; req1_valid = 1'b0; pending = 2'b00;
               break;
            end
            n_cmp++;
            if (early != 0) begin n_bad++; $display("FAIL arb_ready_busy it=%0d: got %0d want 0", it, early); end
            pending[port] = 1'b0;
            tb_pref = (port == 0);
            wait_rsp(ok, which, q, r, err, tmo, cyc);
            n_cmp++;
            if (!ok || which != port || q !== ref_q(ha, hb) || r !== ref_r(ha, hb) || err !== (hb == 8'h00) || tmo !== 1'b0) begin
               n_bad++;
               $display("FAIL arb_rsp it=%0d: got ok=%0d to=%0d q=%0d r=%0d err=%b tmo=%b want to=%0d q=%0d r=%0d err=%b tmo=0",
                        it, ok, which, q, r, err, tmo, port, ref_q(ha, hb), ref_r(ha, hb), hb == 8'h00);
            end
            $display("arb it=%0d port=%0d a=%0d b=%0d q=%0d r=%0d err=%b", it, port, ha, hb, q, r, err);
         end
      end
   endtask

   task automatic test_hold();
      bit ok; int port, early, which, cyc, busy_ready; logic [7:0] ha, hb, q, r; logic err, tmo;
      reset_dut();
      m_lat = 8;
      req0_a = 8'd10; req0_b = 8'd3; req0_valid = 1'b1;
      wait_handshake(0, ok, port, ha, hb, early);
      req1_a = 8'd77; req1_b = 8'd5; req1_valid = 1'b1;
      busy_ready = 0;
      for (int i = 0; i < 100 && busy; i++) begin
         @(negedge clk);
         if (busy && req1_ready) busy_ready++;
         req1_b = 8'($urandom_range(1, 255));
      end
      wait_handshake(0, ok, port, ha, hb, early);
      n_cmp++;
      if (!ok || port != 1 || busy_ready != 0) begin
         n_bad++; $display("FAIL hold_accept: got ok=%0d port=%0d early=%0d want 1/1/0", ok, port, busy_ready);
      end
      req1_b = 8'd1;
      wait_rsp(ok, which, q, r, err, tmo, cyc);
      n_cmp++;
      if (!ok || which != 1 || q !== ref_q(ha, hb) || r !== ref_r(ha, hb)) begin
         n_bad++; $display("FAIL hold_rsp: got to=%0d q=%0d r=%0d want 1 q=%0d r=%0d", which, q, r, ref_q(ha, hb), ref_r(ha, hb));
      end
      $display("test_hold: req1 b at handshake=%0d q=%0d r=%0d", hb, q, r);
   endtask

   task automatic test_timeout();
      bit ok; int port, early, n; logic [7:0] ha, hb;
      reset_dut();
      m_hang = 1;
      m_lat = 5;
      req0_a = 8'd7; req0_b = 8'd3; req0_valid = 1'b1;
      wait_handshake(0, ok, port, ha, hb, early);
      for (int i = 0; i < 20 && dv_start; i++) @(negedge clk);
      n = 0;
      while (!rsp_valid0 && !rsp_valid1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (n != 64 || !rsp_valid0) begin n_bad++; $display("FAIL tmo_lat: got %0d v0=%b want 64 1", n, rsp_valid0); end
      n_cmp++;
      if ({rsp_q, rsp_r, rsp_err, rsp_timeout} !== {8'd0, 8'd0, 1'b1, 1'b1}) begin
         n_bad++; $display("FAIL tmo_val: got q=%0d r=%0d err=%b tmo=%b want 0 0 1 1", rsp_q, rsp_r, rsp_err, rsp_timeout);
      end
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL tmo_idle: got busy=%b want 0", busy); end
      $display("test_timeout: response after %0d cycles, err=%b", n, rsp_err);
   endtask

   task automatic test_zero();
      bit ok; int port, early, which, cyc; logic [7:0] ha, hb, q, r; logic err, tmo;
      reset_dut();
      m_lat = 5;
      dvs_cnt = 0;
      req0_a = 8'h05; req0_b = 8'h00; req0_valid = 1'b1;
      wait_handshake(0, ok, port, ha, hb, early);
      wait_rsp(ok, which, q, r, err, tmo, cyc);
      n_cmp++;
      if (!ok || which != 0 || {q, r, err, tmo} !== {8'hFF, 8'h05, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL zero_rsp: got to=%0d q=%h r=%h err=%b tmo=%b want 0 ff 05 1 0", which, q, r, err, tmo);
      end
`ifdef DIV_ARB_ZERO_BYPASS_EN
      n_cmp++;
      if (dvs_cnt != 0 || cyc != 1) begin n_bad++; $display("FAIL zero_bypass: got starts=%0d lat=%0d want 0 1", dvs_cnt, cyc); end
`else
      n_cmp++;
      if (dvs_cnt != 2) begin n_bad++; $display("FAIL zero_launch: got starts=%0d want 2", dvs_cnt); end
`endif
      $display("test_zero: 5/0 q=%h r=%h err=%b", q, r, err);
   endtask

   task automatic test_reset_mid();
      bit ok; int port, early, which, cyc; logic [7:0] ha, hb, q, r; logic err, tmo;
      reset_dut();
      m_lat = 20;
      req0_a = 8'd50; req0_b = 8'd3; req0_valid = 1'b1;
      wait_handshake(0, ok, port, ha, hb, early);
      repeat (5) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ({dv_start, busy, rsp_valid0, rsp_valid1} !== 4'b0) begin
         n_bad++; $display("FAIL mid_reset: got %b want 0000", {dv_start, busy, rsp_valid0, rsp_valid1});
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      v0_cnt = 0; v1_cnt = 0;
      repeat (30) @(negedge clk);
      n_cmp++;
      if (v0_cnt + v1_cnt != 0) begin n_bad++; $display("FAIL mid_no_rsp: got %0d want 0", v0_cnt + v1_cnt); end
      m_lat = 4;
      req0_a = 8'd200; req0_b = 8'd9; req0_valid = 1'b1;
      wait_handshake(0, ok, port, ha, hb, early);
      wait_rsp(ok, which, q, r, err, tmo, cyc);
      n_cmp++;
      if (!ok || which != 0 || {q, r, err} !== {8'd22, 8'd2, 1'b0}) begin
         n_bad++; $display("FAIL mid_after: got to=%0d q=%0d r=%0d err=%b want 0 22 2 0", which, q, r, err);
      end
      $display("test_reset_mid: post-reset 200/9 q=%0d r=%0d", q, r);
   endtask

   initial begin
      reset = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
      test_reset();
      test_basic();
      test_arbitration();
      test_hold();
      test_timeout();
      test_zero();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
